xbar_pkt_injector: RTL and testbench
====================================

// Module: xbar_pkt_injector
// PURPOSE
//  Source side of the 4x4 crossbar's req/start protocol; drives iport0..3 and start for the switch.
//  Buffers host packets in four per-port FIFOs and builds 15-bit crossbar words.
//  Launches one switch round per req, then holds the words stable until the switch's ready pulse.
//  Word format: [14]=valid, [13]=0, [12:11]=dest, [10]=0, [9:8]=src (=port index), [7:0]=payload.
// PARAMETERS
//  DEPTH    4   entries per port FIFO (power of 2, >=2)
//  TIMEOUT  16  max cycles waiting for sw_ready after start before abort
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   4   host push request, bit p = port p
//  in_ready     out  4   port p FIFO not full
//  in_dest      in   8   dest for port p at [2p+1:2p]
//  in_data      in   32  payload for port p at [8p+7:8p]
//  sw_req       in   1   switch req (switch idle, accepting a round)
//  sw_ready     in   1   switch ready pulse (round complete)
//  start        out  1   round launch, 1-cycle pulse
//  iport0..3    out  15  crossbar words to switch inputs
//  busy         out  1   high in START or WAIT
//  round_cnt    out  16  completed rounds, wraps at 0xFFFF->0
//  err          out  1   sticky timeout flag
// BEHAVIOUR
//  Reset: FIFOs empty; state IDLE; start=0; iport0..3=0; busy=0; round_cnt=0; err=0; in_ready=4'hF.
//  Push: in_valid[p]&in_ready[p] at edge writes {dest,data}; entry visible at FIFO head next cycle.
//  FIFO full: in_ready[p]=0 and in_valid is ignored; no overwrite. Simultaneous push+pop: both take effect, level unchanged.
//  FSM states:
//   IDLE : iport*=0, start=0. If sw_req=1 and any FIFO non-empty -> START.
//          On entry to START, snapshot register snap[p] = non-empty[p].
//          iport_p = snap[p] ? {1,0,head dest,0,p,head data} : 0.
//   START: start=1 for exactly 1 cycle; iport words driven -> WAIT; timer cleared.
//   WAIT : iport words held unchanged; start=0; timer increments each cycle.
//          sw_ready=1 -> pop every FIFO with snap[p]=1 (one entry each); round_cnt+1; -> IDLE.
//          Else timer==TIMEOUT-1 -> err=1, no pop, no count -> IDLE (packets retried later).
//          sw_ready and timeout expiry in the same cycle: sw_ready wins.
//  Latency: push at edge N with sw_req high and the FSM in IDLE -> start=1 in cycle N+2.
//  Back-to-back: after a pop the FSM returns to IDLE; the next START needs sw_req=1 again.
//  Pushes during START/WAIT are accepted but never alter the held iport words or snap.
//  sw_ready seen in IDLE/START: ignored. sw_req while busy: ignored.
//  Empty ports in a round present an all-zero word (valid=0).
//  Reset mid-round: immediate return to reset state; buffered packets are discarded.
// TESTING
//  1) Reset, push p0 dest=2 data=0xA5, sw_req=1 -> start pulse; iport0=15'h50A5; iport1-3=0; busy=1.
//  2) Case 1 then sw_ready pulse 5 cycles later -> iport* cleared next cycle; round_cnt=1; FIFO0 empty.
//  3) Push DEPTH entries into p3 with sw_req=0 -> in_ready[3]=0; 5th push dropped; 4 rounds with
//     sw_ready drain all four in order; iport3 src field=3.
//  4) All 4 ports loaded, sw_ready never arrives -> err=1 at TIMEOUT; FSM in IDLE; no pop;
//     next round re-sends the same heads.
//  5) Push to p1 in the same cycle as the sw_ready pop of p1 (FIFO full) -> level unchanged; the new
//     entry lands at the tail.
//  6) rst asserted in WAIT -> start=0, iport*=0, busy=0, round_cnt=0, FIFOs empty, err cleared.

Source files
------------

// File: rtl/xbar_pkt_injector.sv
// Source side of the 4x4 crossbar req/start handshake: per-port packet FIFOs feed
// 15-bit crossbar words that are launched with start and held until sw_ready.
module xbar_pkt_injector #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_valid,
  output logic [3:0]  in_ready,
  input  logic [7:0]  in_dest,
  input  logic [31:0] in_data,
  input  logic        sw_req,
  input  logic        sw_ready,
  output logic        start,
  output logic [14:0] iport0,
  output logic [14:0] iport1,
  output logic [14:0] iport2,
  output logic [14:0] iport3,
  output logic        busy,
  output logic [15:0] round_cnt,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        nempty, full, push, pop, snap;
  logic [3:0][9:0]   head;
  logic [14:0]       word_q [4];
  logic [TW-1:0]     timer;
  logic              timeout, launch, done, abort;

  for (genvar gp = 0; gp < 4; gp++) begin : g_fifo
    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    assign nempty[gp] = (wr_ptr != rd_ptr);
    assign full[gp]   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO may still accept the push.
    assign in_ready[gp] = ~full[gp] | pop[gp];
    assign push[gp]     = in_valid[gp] & in_ready[gp];
    assign head[gp]     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[gp]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[gp])  rd_ptr <= rd_ptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push[gp]) mem[wr_ptr[AW-1:0]] <= {in_dest[2*gp +: 2], in_data[8*gp +: 8]};
    end
  end

  assign timeout = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sw_req && (|nempty)) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (sw_ready || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start  = (state == START);
    busy   = (state != IDLE);
    launch = (state == IDLE) && (state_nxt == START);
    done   = (state == WAIT) && sw_ready;
    abort  = (state == WAIT) && !sw_ready && timeout;
    pop    = done ? snap : 4'b0000;
  end

  // Round datapath: words are captured at launch and held until the round ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      timer     <= '0;
      round_cnt <= '0;
      err       <= 1'b0;
      for (int p = 0; p < 4; p++) word_q[p] <= '0;
    end else begin
      if (launch) begin
        snap <= nempty;
        for (int p = 0; p < 4; p++)
          word_q[p] <= nempty[p] ? {1'b1, 1'b0, head[p][9:8], 1'b0, 2'(p), head[p][7:0]} : 15'd0;
      end else if (done || abort) begin
        for (int p = 0; p < 4; p++) word_q[p] <= '0;
      end
      if (state == START)     timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (done)  round_cnt <= round_cnt + 16'd1;
      if (abort) err <= 1'b1;
    end
  end

  assign iport0 = word_q[0];
  assign iport1 = word_q[1];
  assign iport2 = word_q[2];
  assign iport3 = word_q[3];

endmodule

// File: tb/tb_xbar_pkt_injector.sv
// Directed bench for xbar_pkt_injector: launch, hold, drain order, timeout retry,
// push-during-pop on a full FIFO and mid-round reset.
module tb_xbar_pkt_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  in_dest;
  logic [31:0] in_data;
  logic        sw_req, sw_ready, start, busy, err;
  logic [14:0] iport0, iport1, iport2, iport3;
  logic [15:0] round_cnt;

  int checks = 0;
  int failures = 0;

  xbar_pkt_injector #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .sw_req(sw_req), .sw_ready(sw_ready),
    .start(start), .iport0(iport0), .iport1(iport1), .iport2(iport2), .iport3(iport3),
    .busy(busy), .round_cnt(round_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 8 && !start; i++) step();
    check(tag, {31'd0, start}, 32'd1);
  endtask

  task automatic do_round(input string tag, input logic [14:0] e0, input logic [14:0] e1,
                          input logic [14:0] e2, input logic [14:0] e3);
    sw_req = 1'b1;
    wait_start({tag, "_start"});
    sw_req = 1'b0;
    check({tag, "_ip0"}, {17'd0, iport0}, {17'd0, e0});
    check({tag, "_ip1"}, {17'd0, iport1}, {17'd0, e1});
    check({tag, "_ip2"}, {17'd0, iport2}, {17'd0, e2});
    check({tag, "_ip3"}, {17'd0, iport3}, {17'd0, e3});
    step();
    sw_ready = 1'b1;
    step();
    sw_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_no_start(input string tag);
    logic seen = 1'b0;
    sw_req = 1'b1;
    repeat (3) begin
      step();
      seen = seen | start;
    end
    sw_req = 1'b0;
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"}, {31'd0, start}, 32'd0);
    check({tag, "_iports"}, {2'd0, iport3, iport2}, 32'd0);
    check({tag, "_iports01"}, {2'd0, iport1, iport0}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cnt"}, {16'd0, round_cnt}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_rdy"}, {28'd0, in_ready}, 32'hF);
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_dest = '0; in_data = '0; sw_req = 1'b0; sw_ready = 1'b0;
    step(); step();
    check_reset_state("rst");
    rst = 1'b0;
    step();

    // 1) single packet on port 0, dest 2, data A5
    in_valid = 4'b0001; in_dest = 8'h02; in_data = 32'h0000_00A5; sw_req = 1'b1;
    step();
    in_valid = 4'b0000;
    check("lat_n1_start", {31'd0, start}, 32'd0);
    step();
    check("t1_start", {31'd0, start}, 32'd1);
    check("t1_ip0", {17'd0, iport0}, 32'h50A5);
    check("t1_ip123", {2'd0, iport3, iport2}, 32'd0);
    check("t1_ip1", {17'd0, iport1}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    sw_req = 1'b0;
    step();
    check("t1_pulse", {31'd0, start}, 32'd0);
    check("t1_hold", {17'd0, iport0}, 32'h50A5);
    // 2) sw_ready five cycles after start
    repeat (3) step();
    sw_ready = 1'b1;
    step();
    sw_ready = 1'b0;
    check("t2_ip0", {17'd0, iport0}, 32'd0);
    check("t2_cnt", {16'd0, round_cnt}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check_no_start("t2_empty");

    // 3) fill port 3, fifth push dropped, drain in order
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("t3_full", {28'd0, in_ready}, 32'h7);
      in_valid = 4'b1000;
      in_dest  = {i[1:0], 6'd0};
      in_data  = {8'h10 + i[7:0], 24'd0};
      step();
    end
    in_valid = 4'b0000;
    check("t3_still_full", {28'd0, in_ready}, 32'h7);
    do_round("t3_r0", 15'h0, 15'h0, 15'h0, 15'h4310);
    do_round("t3_r1", 15'h0, 15'h0, 15'h0, 15'h4B11);
    do_round("t3_r2", 15'h0, 15'h0, 15'h0, 15'h5312);
    do_round("t3_r3", 15'h0, 15'h0, 15'h0, 15'h5B13);
    check("t3_cnt", {16'd0, round_cnt}, 32'd5);
    check_no_start("t3_empty");

    // 4) all ports loaded, no sw_ready: timeout, no pop, retry
    in_valid = 4'b1111; in_dest = 8'b00_11_10_01; in_data = 32'h2322_2120;
    step();
    in_valid = 4'b0000;
    sw_req = 1'b1;
    wait_start("t4_start");
    sw_req = 1'b0;
    check("t4_ip0", {17'd0, iport0}, 32'h4820);
    check("t4_ip1", {17'd0, iport1}, 32'h5121);
    check("t4_ip2", {17'd0, iport2}, 32'h5A22);
    check("t4_ip3", {17'd0, iport3}, 32'h4323);
    repeat (16) step();
    check("t4_wait_busy", {31'd0, busy}, 32'd1);
    check("t4_wait_err", {31'd0, err}, 32'd0);
    step();
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_nocnt", {16'd0, round_cnt}, 32'd5);
    do_round("t4_retry", 15'h4820, 15'h5121, 15'h5A22, 15'h4323);
    check("t4_cnt", {16'd0, round_cnt}, 32'd6);
    check("t4_sticky", {31'd0, err}, 32'd1);

    // 5) push into full port 1 during its pop
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0010; in_dest = 8'b0000_0100; in_data = {16'd0, 8'h30 + i[7:0], 8'd0};
      step();
    end
    in_valid = 4'b0000;
    check("t5_full", {28'd0, in_ready}, 32'hD);
    sw_req = 1'b1;
    wait_start("t5_start");
    sw_req = 1'b0;
    check("t5_ip1", {17'd0, iport1}, 32'h4930);
    step();
    sw_ready = 1'b1;
    in_valid = 4'b0010; in_data = 32'h0000_3400;
    #1;
    check("t5_rdy_pop", {28'd0, in_ready}, 32'hF);
    step();
    sw_ready = 1'b0; in_valid = 4'b0000;
    check("t5_level", {28'd0, in_ready}, 32'hD);
    do_round("t5_r1", 15'h0, 15'h4931, 15'h0, 15'h0);
    do_round("t5_r2", 15'h0, 15'h4932, 15'h0, 15'h0);
    do_round("t5_r3", 15'h0, 15'h4933, 15'h0, 15'h0);
    do_round("t5_r4", 15'h0, 15'h4934, 15'h0, 15'h0);
    check("t5_cnt", {16'd0, round_cnt}, 32'd11);

    // 6) reset in WAIT
    in_valid = 4'b0101; in_dest = 8'h00; in_data = 32'h0077_0066;
    step();
    in_valid = 4'b0100;
    sw_req = 1'b1;
    wait_start("t6_start");
    sw_req = 1'b0; in_valid = 4'b0000;
    step();
    check("t6_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_state("t6");
    step();
    rst = 1'b0;
    check_no_start("t6_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
